// File: rtl/pea_command_scheduler_if.sv
// pea_command_scheduler_if: FIFO status/handshake and datapath control bundle for the PEA scheduler
//   master (scheduler): reads command_in, FIFO populations/free space and dp_done;
//                       drives command_rd_en, status_wr_en, status_out, dp_start and dp_mode/a/b/n.
//   slave (FIFOs + datapath): the opposite directions.
interface pea_command_scheduler_if #(
  parameter int word_size = 16,
  parameter int buffer_size = 1024
);
  localparam int aw = $clog2(buffer_size);
  logic [word_size-1:0] command_in;
  logic [aw-1:0] command_pop;
  logic [aw-1:0] data_pop;
  logic [aw-1:0] result_free_space;
  logic [aw-1:0] status_free_space;
  logic command_rd_en;
  logic status_wr_en;
  logic [2*word_size-1:0] status_out;
  logic dp_start;
  logic [1:0] dp_mode;
  logic [2:0] dp_a;
  logic [4:0] dp_b;
  logic [3:0] dp_n;
  logic dp_done;
  modport master (
    input command_in, command_pop, data_pop, result_free_space, status_free_space, dp_done,
    output command_rd_en, status_wr_en, status_out, dp_start, dp_mode, dp_a, dp_b, dp_n
  );
  modport slave (
    output command_in, command_pop, data_pop, result_free_space, status_free_space, dp_done,
    input command_rd_en, status_wr_en, status_out, dp_start, dp_mode, dp_a, dp_b, dp_n
  );
endinterface

// File: rtl/pea_command_scheduler.sv
// pea_command_scheduler: PEA firing controller that decodes commands, gates them on FIFO resources and sequences the datapath
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : master side of pea_command_scheduler_if (command/status FIFOs, populations, datapath start/done)
module pea_command_scheduler #(
  parameter int word_size = 16,
  parameter int buffer_size = 1024
) (
  input logic clk,
  input logic rst,
  pea_command_scheduler_if.master bus
);
  localparam int aw = $clog2(buffer_size);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, ERROR, WAIT_RES, START, BUSY, STATUS} state_t;
  state_t state, next;
  logic [15:0] cmd;
  logic [7:0] code;
  logic [7:0] valid;
  logic [7:0][3:0] n_tab;
  logic [7:0] op_in, op, dec_code;
  logic [2:0] a_in, a;
  logic [4:0] b_in, b;
  logic st_ok, res_ok, active;
  assign op_in = bus.command_in[15:8];
  assign a_in = bus.command_in[7:5];
  assign b_in = bus.command_in[4:0];
  assign op = cmd[15:8];
  assign a = cmd[7:5];
  assign b = cmd[4:0];
  assign st_ok = bus.status_free_space != '0;
  // Error priority: opcode, STP degree, unset vector, empty batch
  always_comb begin
    dec_code = (op_in == 8'h00 || op_in > 8'h04) ? 8'h01 :
               (op_in == 8'h01 && b_in > 5'd10) ? 8'h02 :
               ((op_in == 8'h02 || op_in == 8'h03) && !valid[a_in]) ? 8'h03 :
               (op_in == 8'h03 && b_in == 5'd0) ? 8'h04 : 8'h00;
  end
  // STP consumes the b+1 coefficients, EVB consumes and produces b words
  always_comb begin
    res_ok = op == 8'h01 ? (bus.data_pop >= aw'(b) + aw'(1)) && st_ok :
             op == 8'h02 ? (bus.data_pop != '0) && (bus.result_free_space != '0) && st_ok :
             (bus.data_pop >= aw'(b)) && (bus.result_free_space >= aw'(b)) && st_ok;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      IDLE: next = bus.command_pop != '0 ? FETCH : IDLE;
      FETCH: next = DECODE;
      DECODE: next = dec_code != 8'h00 ? ERROR : op_in == 8'h04 ? STATUS : WAIT_RES;
      ERROR: next = STATUS;
      WAIT_RES: next = res_ok ? START : WAIT_RES;
      START: next = BUSY;
      BUSY: next = bus.dp_done ? STATUS : BUSY;
      STATUS: next = st_ok ? IDLE : STATUS;
      default: next = IDLE;
    endcase
  end
  // FIFO read data appears the cycle after rd_en, so the token is captured in DECODE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd <= '0;
      code <= '0;
      valid <= '0;
      n_tab <= '0;
    end else if (state == DECODE) begin
      cmd <= bus.command_in[15:0];
      code <= dec_code;
      if (dec_code == 8'h00 && op_in == 8'h04) begin
        valid <= '0;
        n_tab <= '0;
      end
    end else if (state == BUSY && bus.dp_done) begin
      code <= 8'h00;
      if (op == 8'h01) begin
        valid[a] <= 1'b1;
        n_tab[a] <= b[3:0];
      end
    end
  end
  always_comb begin
    active = state == START || state == BUSY;
    bus.command_rd_en = state == FETCH;
    bus.dp_start = state == START;
    bus.status_wr_en = state == STATUS && st_ok;
    bus.dp_mode = active ? op[1:0] : 2'd0;
    bus.dp_a = active ? a : 3'd0;
    bus.dp_b = active ? b : 5'd0;
    bus.dp_n = active ? n_tab[a] : 4'd0;
  end
  assign bus.status_out = {{(word_size-16){1'b0}}, cmd, {(word_size-8){1'b0}}, code};
endmodule

// File: tb/tb_pea_command_scheduler.sv
// tb_pea_command_scheduler: directed vector bench for the PEA command scheduler
module tb_pea_command_scheduler;
  typedef struct {
    logic [15:0] cmd;
    logic [9:0] dpop0;
    logic [9:0] dpop;
    int hold;
    bit start;
    logic [1:0] mode;
    logic [2:0] a;
    logic [4:0] b;
    logic [3:0] n;
    logic [31:0] status;
    int lat;
  } vec_t;
  logic clk, rst;
  int checks, failures;
  vec_t vt [14];
  pea_command_scheduler_if #(.word_size(16), .buffer_size(1024)) bus ();
  pea_command_scheduler #(.word_size(16), .buffer_size(1024)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(logic [15:0] cmd, int dpop0, int dpop, int hold, bit st, int mode, int a, int b, int n, logic [31:0] status, int lat);
    vec_t v;
    v.cmd = cmd;
    v.dpop0 = 10'(dpop0);
    v.dpop = 10'(dpop);
    v.hold = hold;
    v.start = st;
    v.mode = 2'(mode);
    v.a = 3'(a);
    v.b = 5'(b);
    v.n = 4'(n);
    v.status = status;
    v.lat = lat;
    return v;
  endfunction
  function automatic logic [49:0] outs();
    return {bus.command_rd_en, bus.status_wr_en, bus.dp_start, bus.dp_mode, bus.dp_a, bus.dp_b, bus.dp_n, bus.status_out};
  endfunction
  task automatic run(input vec_t v);
    int starts, since, start_c;
    bit got, sent;
    starts = 0; since = -1; start_c = -1; got = 0; sent = 0;
    bus.command_in = v.cmd;
    bus.data_pop = v.dpop0;
    bus.result_free_space = 10'd8;
    bus.status_free_space = 10'd8;
    bus.command_pop = 10'd1;
    for (int c = 0; c < 80 && !got; c++) begin
      @(negedge clk);
      if (c == v.hold) bus.data_pop = v.dpop;
      if (bus.command_rd_en) bus.command_pop = 10'd0;
      if (bus.dp_done) bus.dp_done = 1'b0;
      else if (since >= 1 && !sent) begin bus.dp_done = 1'b1; sent = 1; end
      if (since >= 0) since++;
      if (bus.dp_start) begin
        starts++;
        if (since < 0) begin since = 0; start_c = c; end
        chk($sformatf("dp_fields %h", v.cmd), {bus.dp_mode, bus.dp_a, bus.dp_b, bus.dp_n}, {v.mode, v.a, v.b, v.n});
      end
      if (bus.status_wr_en) begin
        got = 1;
        chk($sformatf("status %h", v.cmd), bus.status_out, v.status);
        if (v.lat > 0) chk($sformatf("latency %h", v.cmd), c + 1, v.lat);
      end
    end
    chk($sformatf("status_seen %h", v.cmd), got, 1);
    chk($sformatf("starts %h", v.cmd), starts, v.start);
    if (v.hold > 0) chk($sformatf("held %h", v.cmd), start_c > v.hold, 1);
    @(negedge clk);
    chk($sformatf("wr_once %h", v.cmd), bus.status_wr_en, 0);
  endtask
  task automatic wait_start(input string name);
    bit seen;
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (bus.command_rd_en) bus.command_pop = 10'd0;
      seen = bus.dp_start;
    end
    chk(name, seen, 1);
  endtask
  initial begin
    int wr, acc;
    logic [31:0] st;
    checks = 0; failures = 0;
    vt[0] = mk(16'h0143, 4, 4, 0, 1, 1, 2, 3, 0, 32'h0143_0000, 0);
    vt[1] = mk(16'h02A0, 4, 4, 0, 0, 0, 0, 0, 0, 32'h02A0_0003, 4);
    vt[2] = mk(16'h0240, 1, 1, 0, 1, 2, 2, 0, 3, 32'h0240_0000, 0);
    vt[3] = mk(16'h0743, 4, 4, 0, 0, 0, 0, 0, 0, 32'h0743_0001, 4);
    vt[4] = mk(16'h014C, 16, 16, 0, 0, 0, 0, 0, 0, 32'h014C_0002, 4);
    vt[5] = mk(16'h0340, 4, 4, 0, 0, 0, 0, 0, 0, 32'h0340_0004, 4);
    vt[6] = mk(16'h0344, 2, 4, 10, 1, 3, 2, 4, 3, 32'h0344_0000, 0);
    vt[7] = mk(16'h01EA, 10, 11, 8, 1, 1, 7, 10, 0, 32'h01EA_0000, 0);
    vt[8] = mk(16'h0140, 1, 1, 0, 1, 1, 2, 0, 3, 32'h0140_0000, 0);
    vt[9] = mk(16'h0240, 1, 1, 0, 1, 2, 2, 0, 0, 32'h0240_0000, 0);
    vt[10] = mk(16'h0400, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0400_0000, 0);
    vt[11] = mk(16'h0240, 4, 4, 0, 0, 0, 0, 0, 0, 32'h0240_0003, 4);
    vt[12] = mk(16'h0000, 4, 4, 0, 0, 0, 0, 0, 0, 32'h0000_0001, 4);
    vt[13] = mk(16'h0340, 4, 4, 0, 0, 0, 0, 0, 0, 32'h0340_0003, 4);
    rst = 1'b0;
    bus.command_in = '0; bus.command_pop = '0; bus.data_pop = '0;
    bus.result_free_space = '0; bus.status_free_space = '0; bus.dp_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    rst = 1'b1;
    bus.status_free_space = 10'd8;
    bus.result_free_space = 10'd8;
    bus.data_pop = 10'd8;
    acc = 0;
    repeat (20) begin
      @(negedge clk);
      acc = acc | {bus.command_rd_en, bus.status_wr_en, bus.dp_start};
    end
    chk("idle_quiet", acc, 0);
    for (int i = 0; i <= 9; i++) run(vt[i]);
    bus.command_in = 16'h0240; bus.data_pop = 10'd1; bus.command_pop = 10'd1;
    wait_start("sf_start");
    bus.status_free_space = 10'd0;
    @(negedge clk);
    bus.dp_done = 1'b1;
    @(negedge clk);
    bus.dp_done = 1'b0;
    wr = 0;
    repeat (10) begin
      if (bus.status_wr_en) wr++;
      @(negedge clk);
    end
    chk("sf_held_no_write", wr, 0);
    bus.status_free_space = 10'd1;
    wr = 0; st = '0;
    repeat (5) begin
      #1;
      if (bus.status_wr_en) begin wr++; st = bus.status_out; end
      @(negedge clk);
    end
    chk("sf_single_write", wr, 1);
    chk("sf_status", st, 32'h0240_0000);
    bus.status_free_space = 10'd8;
    bus.command_in = 16'h0240; bus.data_pop = 10'd1; bus.command_pop = 10'd1;
    wait_start("rb_start");
    @(negedge clk);
    chk("rb_busy_mode", bus.dp_mode, 2'd2);
    rst = 1'b0;
    #1;
    chk("rb_async_outputs", outs(), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run(vt[11]);
    for (int i = 10; i <= 13; i++) run(vt[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pea_command_scheduler.md
Name: pea_command_scheduler

Overview:
- Firing controller for the Polynomial Evaluation Accelerator (PEA).
- Pops 16-bit command tokens from the Command Input FIFO and decodes them as STP, EVP, EVB or RST.
- Checks FIFO populations and free space, then sequences the PEA arithmetic datapath through a start/done handshake.
- Owns the per-vector degree/valid table and emits exactly one status token per command. Coefficient storage and evaluation live in the datapath; data/result FIFO traffic is driven by the datapath.

Parameters:
- word_size, 16, command token width.
- buffer_size, 1024, words per FIFO; population/free-space ports are log2(buffer_size) bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- command_in  input  word_size  command token: [15:8] opcode, [7:5] arg1 (vector index A), [4:0] arg2 (b).
- command_pop  input  log2(buffer_size)  Command Input FIFO population.
- data_pop  input  log2(buffer_size)  Data Input FIFO population.
- result_free_space  input  log2(buffer_size)  Result Output FIFO empty words.
- status_free_space  input  log2(buffer_size)  Status Output FIFO empty words.
- command_rd_en  output  1  one-cycle pop of Command Input FIFO.
- status_wr_en  output  1  one-cycle write of status token.
- status_out  output  2*word_size  status token {command[15:0], 8'h00, code[7:0]}.
- dp_start  output  1  one-cycle datapath start pulse.
- dp_mode  output  2  01 STP, 10 EVP, 11 EVB (held from START to done).
- dp_a  output  3  vector index (held).
- dp_b  output  5  arg2 (held).
- dp_n  output  4  stored degree N[A] (held).
- dp_done  input  1  datapath completion pulse.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; valid[7:0]=0; N[*]=0; latched command=0.
- Opcodes: 8'h01 STP, 8'h02 EVP, 8'h03 EVB, 8'h04 RST; anything else is invalid.
- Status codes: 00 OK, 01 bad opcode, 02 STP b>10, 03 vector A not set, 04 EVB b=0.
- FSM states (all outputs registered/Moore):
  - IDLE: command_pop>0 -> FETCH.
  - FETCH: command_rd_en=1 for exactly one cycle -> DECODE.
  - DECODE: latch command_in (FIFO data is valid the cycle after rd_en), then classify:
    - error -> ERROR;
    - RST -> clear valid[*] and N[*], code 00 -> STATUS;
    - STP/EVP/EVB -> WAIT_RES.
  - ERROR: code set -> STATUS (no datapath activity).
  - WAIT_RES: stay until the resource condition for the opcode holds, then go to START. No timeout. Conditions:
    - STP: data_pop>=b+1 and status_free_space>=1.
    - EVP: data_pop>=1, result_free_space>=1, status_free_space>=1.
    - EVB: data_pop>=b, result_free_space>=b, status_free_space>=1.
  - START: dp_start=1 for one cycle; dp_mode/dp_a/dp_b/dp_n valid this cycle and held -> BUSY.
  - BUSY: wait for dp_done.
    - On dp_done: code 00. If STP, set valid[A]=1 and N[A]=b[3:0] on the same edge. -> STATUS.
    - dp_done in any other state is ignored.
  - STATUS: if status_free_space>=1, status_wr_en=1 for one cycle with status_out valid -> IDLE; otherwise hold in STATUS.
- Error checks, evaluated in DECODE in priority order: opcode, then STP b>10, then EVP/EVB on invalid A, then EVB b=0.
- Latency, best case for an error or RST command: IDLE to status_wr_en is 4 clocks.
- Only one command is in flight; command_rd_en never asserts outside FETCH.
- STP on an already-set A overwrites N[A]. An STP with b=0 is legal (degree-0 vector).
- Arithmetic: b+1 is computed at log2(buffer_size) width, no overflow for b<=31. Comparisons are unsigned.
- Reset mid-operation: immediate return to IDLE, table cleared, any pending status is lost. The datapath shares rst.

Test Plan:
- Reset then command_pop=0 -> FSM stays IDLE; command_rd_en, status_wr_en, dp_start all 0 indefinitely.
- STP A=2 b=3 (token 16'h0143), data_pop=4, free spaces=8 -> one dp_start with dp_mode=01, dp_a=2, dp_b=3; after dp_done, status_out=32'h0143_0000; valid[2]=1, N[2]=3.
- EVP A=5 before any STP (token 16'h02A0) -> no dp_start; status code 03 (status_out=32'h02A0_0003).
- EVB A=2 b=4 with data_pop=2 -> held in WAIT_RES; raise data_pop to 4 -> dp_start with dp_mode=11, dp_n=3; status 00.
- Opcode 8'h07, then STP b=12 -> status codes 01 then 02; no dp_start. Then RST -> status 00 and valid cleared, so a following EVP returns 03.
- status_free_space=0 after dp_done -> held in STATUS with no write; free space 1 -> single status_wr_en. Assert rst during BUSY -> all outputs 0 asynchronously and table cleared.
